// File: rtl/input_port_buffer.sv
// -----------------------------------------------------------------------------
// input_port_buffer
//
// Per-direction input buffer of the NoC router. Flits from the upstream link
// are stored in a first-word-fall-through FIFO. The read side tracks packet
// boundaries so the arbiter can see, for the flit at the head, whether it is
// a header or a tail and which YX destination the current packet targets.
//
// Parameters
//   FLIT_WIDTH   : flit width in bits; bits [7:0] of a header carry YX dest
//   DEPTH        : FIFO entries, power of two, >= 2
//   PACKET_FLITS : fixed number of flits per packet (header included), >= 2
//
// Ports
//   clk              : system clock, all state on the rising edge
//   reset            : synchronous, active-high reset
//   ib_write_i       : upstream write strobe
//   ib_data_i        : upstream flit
//   ib_read_i        : pop request (arbiter read grant for this port)
//   ib_data_o        : head flit, 0 when empty
//   ib_empty_o       : FIFO holds no flits
//   ib_full_o        : FIFO holds DEPTH flits
//   ib_addr_header_o : YX destination of the packet currently at the head
//   ib_header_o      : head flit is a packet header
//   ib_tail_o        : head flit is the last flit of its packet
//   ib_overflow_o    : sticky, a write was dropped
//   ib_underflow_o   : sticky, a read was issued while empty
// -----------------------------------------------------------------------------
module input_port_buffer #(
  parameter int FLIT_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int PACKET_FLITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ib_write_i,
  input  logic [FLIT_WIDTH-1:0] ib_data_i,
  input  logic                  ib_read_i,
  output logic [FLIT_WIDTH-1:0] ib_data_o,
  output logic                  ib_empty_o,
  output logic                  ib_full_o,
  output logic [7:0]            ib_addr_header_o,
  output logic                  ib_header_o,
  output logic                  ib_tail_o,
  output logic                  ib_overflow_o,
  output logic                  ib_underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PACKET_FLITS);

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_FLIT  = CW'(PACKET_FLITS - 1);

  // Storage and FIFO bookkeeping
  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;

  // Read-side packet tracking
  logic [CW-1:0]         rd_flit_cnt;
  logic [7:0]            hdr_reg;

  // Sticky error flags
  logic                  overflow_q;
  logic                  underflow_q;

  // Combinational decode
  logic                  empty;
  logic                  full;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [FLIT_WIDTH-1:0] head;
  logic                  at_header;

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    empty     = (count == '0);
    full      = (count == FULL_COUNT);
    head      = mem[rd_ptr];
    rd_acc    = ib_read_i & ~empty;
    // A write into a full FIFO is accepted when a pop frees a slot in the
    // same cycle, which keeps full-rate streaming through a full buffer.
    wr_acc    = ib_write_i & (~full | rd_acc);
    at_header = ~empty & (rd_flit_cnt == '0);
  end

  // NOTE: the storage array is deliberately left out of reset. Stale entries
  // are unreachable because empty masks the output and the pointers restart,
  // and leaving it unreset lets the array map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= ib_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_flit_cnt <= '0;
      hdr_reg     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (rd_flit_cnt == LAST_FLIT) begin
          rd_flit_cnt <= '0;
        end else begin
          rd_flit_cnt <= rd_flit_cnt + 1'b1;
        end
        // Capture the destination as the header leaves, so it stays
        // visible for the body and tail flits of the same packet.
        if (rd_flit_cnt == '0) begin
          hdr_reg <= head[7:0];
        end
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (ib_write_i && !wr_acc) begin
        overflow_q <= 1'b1;
      end
      if (ib_read_i && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Output drive
  always_comb begin
    ib_empty_o       = empty;
    ib_full_o        = full;
    ib_data_o        = empty ? '0 : head;
    ib_header_o      = at_header;
    ib_tail_o        = ~empty & (rd_flit_cnt == LAST_FLIT);
    // While the header sits at the head its address comes straight from
    // storage; afterwards the captured copy holds it for the rest of the
    // packet.
    ib_addr_header_o = at_header ? head[7:0] : hdr_reg;
    ib_overflow_o    = overflow_q;
    ib_underflow_o   = underflow_q;
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// -----------------------------------------------------------------------------
// tb_input_port_buffer
//
// Directed bench for input_port_buffer (FLIT_WIDTH=32, DEPTH=4,
// PACKET_FLITS=4). Accepted writes push the hand-computed expected pop
// response into a scoreboard queue; a monitor compares every pop the DUT
// performs against the queue head. Status flags are checked inline.
// -----------------------------------------------------------------------------
module tb_input_port_buffer;

  typedef struct packed {
    logic [31:0] data;
    logic        header;
    logic        tail;
    logic [7:0]  addr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ib_write_i;
  logic [31:0] ib_data_i;
  logic        ib_read_i;
  logic [31:0] ib_data_o;
  logic        ib_empty_o;
  logic        ib_full_o;
  logic [7:0]  ib_addr_header_o;
  logic        ib_header_o;
  logic        ib_tail_o;
  logic        ib_overflow_o;
  logic        ib_underflow_o;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  input_port_buffer #(
    .FLIT_WIDTH  (32),
    .DEPTH       (4),
    .PACKET_FLITS(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ib_write_i      (ib_write_i),
    .ib_data_i       (ib_data_i),
    .ib_read_i       (ib_read_i),
    .ib_data_o       (ib_data_o),
    .ib_empty_o      (ib_empty_o),
    .ib_full_o       (ib_full_o),
    .ib_addr_header_o(ib_addr_header_o),
    .ib_header_o     (ib_header_o),
    .ib_tail_o       (ib_tail_o),
    .ib_overflow_o   (ib_overflow_o),
    .ib_underflow_o  (ib_underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the edge.
  task automatic do_op(input logic w, input logic [31:0] d, input logic r);
    ib_write_i = w;
    ib_data_i  = d;
    ib_read_i  = r;
    @(posedge clk);
    #1;
    ib_write_i = 1'b0;
    ib_read_i  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d, input logic h, input logic t, input logic [7:0] a);
    sb.push_back('{data: d, header: h, tail: t, addr: a});
    do_op(1'b1, d, 1'b0);
  endtask

  // Monitor: a pop happens on every cycle with read asserted and data present.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && ib_read_i && !ib_empty_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got data %0h expected no pop", ib_data_o);
      end else begin
        e = sb.pop_front();
        check("pop_data",   ib_data_o,        e.data);
        check("pop_header", 32'(ib_header_o), 32'(e.header));
        check("pop_tail",   32'(ib_tail_o),   32'(e.tail));
        check("pop_addr",   32'(ib_addr_header_o), 32'(e.addr));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Three back-to-back packets, hand-built expected responses.
  exp_t stream [12];

  initial begin : stim
    int wi;
    int cyc;
    logic w;
    logic r;

    stream[0]  = '{32'hE000_0012, 1'b1, 1'b0, 8'h12};
    stream[1]  = '{32'hE001_00A1, 1'b0, 1'b0, 8'h12};
    stream[2]  = '{32'hE002_00A2, 1'b0, 1'b0, 8'h12};
    stream[3]  = '{32'hE003_00A3, 1'b0, 1'b1, 8'h12};
    stream[4]  = '{32'hE010_0030, 1'b1, 1'b0, 8'h30};
    stream[5]  = '{32'hE011_00B1, 1'b0, 1'b0, 8'h30};
    stream[6]  = '{32'hE012_00B2, 1'b0, 1'b0, 8'h30};
    stream[7]  = '{32'hE013_00B3, 1'b0, 1'b1, 8'h30};
    stream[8]  = '{32'hE020_0003, 1'b1, 1'b0, 8'h03};
    stream[9]  = '{32'hE021_00C1, 1'b0, 1'b0, 8'h03};
    stream[10] = '{32'hE022_00C2, 1'b0, 1'b0, 8'h03};
    stream[11] = '{32'hE023_00C3, 1'b0, 1'b1, 8'h03};

    reset      = 1'b1;
    ib_write_i = 1'b0;
    ib_data_i  = '0;
    ib_read_i  = 1'b0;
    do_op(1'b0, '0, 1'b0);
    do_op(1'b0, '0, 1'b0);
    reset = 1'b0;
    do_op(1'b0, '0, 1'b0);

    // Reset state
    check("rst_empty",  32'(ib_empty_o),       32'd1);
    check("rst_full",   32'(ib_full_o),        32'd0);
    check("rst_data",   ib_data_o,             32'd0);
    check("rst_addr",   32'(ib_addr_header_o), 32'd0);
    check("rst_header", 32'(ib_header_o),      32'd0);
    check("rst_tail",   32'(ib_tail_o),        32'd0);
    check("rst_ovf",    32'(ib_overflow_o),    32'd0);
    check("rst_unf",    32'(ib_underflow_o),   32'd0);

    // Single packet, header address visible one cycle after the write
    wr(32'hA000_0021, 1'b1, 1'b0, 8'h21);
    check("p1_empty",  32'(ib_empty_o),       32'd0);
    check("p1_header", 32'(ib_header_o),      32'd1);
    check("p1_addr",   32'(ib_addr_header_o), 32'h21);
    check("p1_data",   ib_data_o,             32'hA000_0021);
    wr(32'hB100_00F1, 1'b0, 1'b0, 8'h21);
    wr(32'hB200_00F2, 1'b0, 1'b0, 8'h21);
    wr(32'hCC00_00FF, 1'b0, 1'b1, 8'h21);
    repeat (4) do_op(1'b0, '0, 1'b1);
    check("p1_drained", 32'(ib_empty_o), 32'd1);
    check("p1_data0",   ib_data_o,       32'd0);

    // Fill to full, simultaneous read+write at full, then a dropped write
    wr(32'h1000_0045, 1'b1, 1'b0, 8'h45);
    wr(32'h2000_0002, 1'b0, 1'b0, 8'h45);
    wr(32'h3000_0003, 1'b0, 1'b0, 8'h45);
    check("fill3_full", 32'(ib_full_o), 32'd0);
    wr(32'h4000_0004, 1'b0, 1'b1, 8'h45);
    check("fill4_full", 32'(ib_full_o),     32'd1);
    check("fill4_ovf",  32'(ib_overflow_o), 32'd0);
    sb.push_back('{data: 32'h5000_005A, header: 1'b1, tail: 1'b0, addr: 8'h5A});
    do_op(1'b1, 32'h5000_005A, 1'b1);
    check("rw_full", 32'(ib_full_o),     32'd1);
    check("rw_ovf",  32'(ib_overflow_o), 32'd0);
    do_op(1'b1, 32'hDEAD_0099, 1'b0);
    check("drop_ovf",  32'(ib_overflow_o), 32'd1);
    check("drop_full", 32'(ib_full_o),     32'd1);
    repeat (4) do_op(1'b0, '0, 1'b1);
    check("after_rw_empty", 32'(ib_empty_o), 32'd1);
    wr(32'h6000_0006, 1'b0, 1'b0, 8'h5A);
    wr(32'h7000_0007, 1'b0, 1'b0, 8'h5A);
    wr(32'h8000_0008, 1'b0, 1'b1, 8'h5A);
    repeat (3) do_op(1'b0, '0, 1'b1);
    check("p2_empty", 32'(ib_empty_o), 32'd1);

    // Underflow: read while empty changes nothing else
    do_op(1'b0, '0, 1'b1);
    check("unf_flag",   32'(ib_underflow_o), 32'd1);
    check("unf_empty",  32'(ib_empty_o),     32'd1);
    check("unf_data",   ib_data_o,           32'd0);
    check("unf_header", 32'(ib_header_o),    32'd0);

    // Stream three packets with stalls on both sides
    wi  = 0;
    cyc = 0;
    while ((wi < 12 || !ib_empty_o) && cyc < 200) begin
      r = !ib_empty_o && (cyc % 4 != 2);
      w = (wi < 12) && (cyc % 5 != 3) && (!ib_full_o || r);
      if (w) begin
        sb.push_back(stream[wi]);
        do_op(1'b1, stream[wi].data, r);
        wi++;
      end else begin
        do_op(1'b0, '0, r);
      end
      cyc++;
    end
    check("stream_in_time", 32'(cyc < 200),    32'd1);
    check("stream_sb_empty", 32'(sb.size()),   32'd0);
    check("stream_ovf_sticky", 32'(ib_overflow_o), 32'd1);

    // Partial packet then reset mid-packet
    wr(32'hF000_0066, 1'b1, 1'b0, 8'h66);
    wr(32'hF001_00D1, 1'b0, 1'b0, 8'h66);
    do_op(1'b0, '0, 1'b1);
    check("mid_header", 32'(ib_header_o),      32'd0);
    check("mid_addr",   32'(ib_addr_header_o), 32'h66);
    reset = 1'b1;
    sb.delete();
    do_op(1'b1, 32'hBAD0_00EE, 1'b1);
    reset = 1'b0;
    check("mrst_empty", 32'(ib_empty_o),       32'd1);
    check("mrst_data",  ib_data_o,             32'd0);
    check("mrst_addr",  32'(ib_addr_header_o), 32'd0);
    check("mrst_ovf",   32'(ib_overflow_o),    32'd0);
    check("mrst_unf",   32'(ib_underflow_o),   32'd0);
    wr(32'h9000_009C, 1'b1, 1'b0, 8'h9C);
    check("post_header", 32'(ib_header_o),      32'd1);
    check("post_addr",   32'(ib_addr_header_o), 32'h9C);
    check("post_tail",   32'(ib_tail_o),        32'd0);
    wr(32'h9001_0001, 1'b0, 1'b0, 8'h9C);
    wr(32'h9002_0002, 1'b0, 1'b0, 8'h9C);
    wr(32'h9003_0003, 1'b0, 1'b1, 8'h9C);
    repeat (4) do_op(1'b0, '0, 1'b1);
    check("final_empty",    32'(ib_empty_o), 32'd1);
    check("final_sb_empty", 32'(sb.size()),  32'd0);

    do_op(1'b0, '0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
